// File: rtl/seq_sched_pkg.sv
// Shared types and width helpers for the sequence-detector scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GUARD, S_REPORT} state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int ID_W  = id_width(4);
  localparam int CNT_W = cnt_width(8);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from last_grant+1, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  input  logic          i_enable,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_pick_idx
);

  always_comb begin
    logic found;
    found      = 1'b0;
    o_pick     = '0;
    o_pick_idx = '0;
    for (int k = 1; k <= N; k++) begin
      automatic int idx = (int'(i_last_grant) + k) % N;
      if (i_enable && !found && i_req[idx]) begin
        found       = 1'b1;
        o_pick[idx] = 1'b1;
        o_pick_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one serial 1011 detector between N word requesters; one word
// is shifted MSB-first, flushed with guard zeros, and its match count reported.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int GUARD   = 2,
  parameter int DET_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N-1:0]              req,
  input  logic [N*W-1:0]            req_data,
  output logic [N-1:0]              grant,
  output logic                      det_in,
  input  logic                      det_out,
  output logic                      rsp_valid,
  output logic [id_width(N)-1:0]    rsp_id,
  output logic [cnt_width(W)-1:0]   rsp_count,
  output logic                      busy
);

  localparam int IDW = id_width(N);
  localparam int CW  = cnt_width(W);
  localparam int BW  = (W > 1) ? $clog2(W) : 1;
  localparam int GW  = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_e           r_state;
  logic [W-1:0]     r_shift;
  logic [BW-1:0]    r_bit;
  logic [GW-1:0]    r_gcnt;
  logic [IDW-1:0]   r_gid;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [DET_LAT-1:0] r_en_pipe;

  logic [N-1:0]     w_pick;
  logic [IDW-1:0]   w_pick_idx;
  logic [IDW-1:0]   w_last_grant;
  logic             w_cnt_en;
  logic [CW-1:0]    w_cnt_next;

  // r_ptr is the highest-priority index; the arbiter wants the one before it.
  assign w_last_grant = (r_ptr == '0) ? IDW'(N - 1) : r_ptr - 1'b1;
  assign w_cnt_en     = r_en_pipe[DET_LAT-1];
  assign w_cnt_next   = r_cnt + CW'(w_cnt_en && det_out);
  assign det_in       = (r_state == S_SHIFT) && r_shift[W-1];
  assign busy         = (r_state != S_IDLE);

  rr_arbiter #(.N(N)) u_arb (
    .i_req        (req),
    .i_last_grant (w_last_grant),
    .i_enable     (r_state == S_IDLE),
    .o_pick       (w_pick),
    .o_pick_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_gcnt    <= '0;
      r_gid     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_en_pipe <= '0;
      grant     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
    end else begin
      grant     <= '0;
      rsp_valid <= 1'b0;
      r_cnt     <= w_cnt_next;
      r_en_pipe[0] <= (r_state == S_SHIFT);
      for (int i = 1; i < DET_LAT; i++) r_en_pipe[i] <= r_en_pipe[i-1];

      case (r_state)
        S_IDLE: begin
          if (|w_pick) begin
            grant   <= w_pick;
            r_gid   <= w_pick_idx;
            r_shift <= req_data[int'(w_pick_idx)*W +: W];
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= r_shift << 1;
          if (r_bit == BW'(W - 1)) begin
            r_gcnt  <= '0;
            r_state <= S_GUARD;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        S_GUARD: begin
          // The last detector result lands on this edge when DET_LAT == GUARD.
          if (r_gcnt == GW'(GUARD - 1)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_gid;
            rsp_count <= w_cnt_next;
            r_state   <= S_REPORT;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        S_REPORT: begin
          r_ptr   <= (r_gid == IDW'(N - 1)) ? '0 : r_gid + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler with a behavioural 1011 detector.
module tb_seq_detect_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        det_in;
  logic        det_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_count;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detect_scheduler #(.N(4), .W(8), .GUARD(2), .DET_LAT(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .det_in    (det_in),
    .det_out   (det_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  // Overlapping 1011 detector, registered output (one cycle latency).
  logic [3:0] hist;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist    <= '0;
      det_out <= 1'b0;
    end else begin
      hist    <= {hist[2:0], det_in};
      det_out <= ({hist[2:0], det_in} == 4'b1011);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one word on requester idx and check grant, serial bits, latency and result.
  task automatic run_word(input string tag, input int idx, input logic [7:0] data,
                          input int exp_cnt, input bit keep);
    logic [7:0] bits;
    logic [3:0] hot;
    int n;
    hot = '0;
    hot[idx] = 1'b1;
    req[idx] = 1'b1;
    req_data[idx*8 +: 8] = data;
    n = 0;
    do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 20);
    chk({tag, "_grant"}, 32'(grant), 32'(hot));
    bits = '0;
    for (int k = 0; k < 8; k++) begin
      bits[7-k] = det_in;
      if (k == 1) chk({tag, "_grant_pulse"}, 32'(grant), 32'h0);
      @(negedge clk);
    end
    if (!keep) req = '0;
    n = 8;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_det_bits"}, 32'(bits), 32'(data));
    chk({tag, "_latency"}, 32'(n), 32'd10);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(idx));
    chk({tag, "_rsp_count"}, 32'(rsp_count), 32'(exp_cnt));
    @(negedge clk);
    chk({tag, "_idle_hold"}, {26'h0, busy, rsp_valid, rsp_count},
        {26'h0, 1'b0, 1'b0, 4'(exp_cnt)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[6];
    int cnt[6];
    int last_rv;
    int n;
    bit seen;
    logic [3:0] hot;

    ord = '{0, 1, 3, 0, 1, 3};
    cnt = '{2, 1, 2, 2, 1, 2};

    // Reset hold with every requester asking.
    rstn = 1'b0;
    req = 4'b1111;
    req_data = {8'hB6, 8'hB6, 8'hB6, 8'hB6};
    repeat (3) @(negedge clk);
    chk("rst_outs", {28'h0, grant}, 32'h0);
    chk("rst_flags", {29'h0, rsp_valid, busy, det_in}, 32'h0);
    chk("rst_rsp", {26'h0, rsp_id, rsp_count}, 32'h0);
    rstn = 1'b1;
    run_word("rst_first", 0, 8'hB6, 2, 1'b0);

    // Single words and counts.
    run_word("b6", 0, 8'hB6, 2, 1'b0);
    run_word("2d", 1, 8'h2D, 1, 1'b0);
    run_word("bb", 2, 8'hBB, 2, 1'b0);

    // Back-to-back words on one requester must not share a match.
    run_word("iso_a", 2, 8'h05, 0, 1'b1);
    run_word("iso_b", 2, 8'h80, 0, 1'b0);
    run_word("zero", 3, 8'h00, 0, 1'b0);

    // Round-robin with req held; pointer is back at 0 here.
    req_data = {8'hBB, 8'h00, 8'h2D, 8'hB6};
    req = 4'b1011;
    last_rv = 0;
    for (int j = 0; j < 6; j++) begin
      hot = '0;
      hot[ord[j]] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 20);
      chk($sformatf("rr%0d_grant", j), 32'(grant), 32'(hot));
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 30);
      chk($sformatf("rr%0d_id", j), 32'(rsp_id), 32'(ord[j]));
      chk($sformatf("rr%0d_count", j), 32'(rsp_count), 32'(cnt[j]));
      if (j > 0) chk($sformatf("rr%0d_spacing", j), 32'(cyc - last_rv), 32'd12);
      last_rv = cyc;
      if (j == 5) req = '0;
    end
    @(negedge clk);

    // Reset while bit 4 of a word is on det_in.
    req = 4'b0001;
    req_data[7:0] = 8'hBB;
    n = 0;
    do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 20);
    chk("mid_grant", 32'(grant), 32'h1);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    req = '0;
    @(negedge clk);
    chk("mid_rst_state", {27'h0, busy, grant}, 32'h0);
    chk("mid_rst_count", 32'(rsp_count), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) rstn = 1'b1;
      seen |= rsp_valid;
      @(negedge clk);
    end
    chk("mid_no_rsp", 32'(seen), 32'h0);
    run_word("post_rst", 0, 8'hBB, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
